data_memory_sized: RTL and testbench

- Parametrised word-organised data memory for the single-cycle/pipelined datapath.
- Replaces the plain word-only memory with sized accesses: byte, half and word stores use per-lane enables; loads are sign- or zero-extended.
- Read data is registered, giving a one-cycle load response with a valid strobe.
- Detects misaligned and out-of-range accesses and suppresses them with fault flags, instead of aliasing them silently.

---
 rtl/data_memory_sized_pkg.sv | 27 ++
 rtl/data_memory_sized_load_align.sv | 30 +++
 rtl/data_memory_sized.sv | 102 ++++++++++
 tb/tb_data_memory_sized.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_sized_pkg.sv
// Shared definitions for the sized data memory: access-size encoding,
// lane count and the byte-enable generator.
package mem_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  function automatic logic [LANES-1:0] byte_enable(input logic [1:0] size,
                                                   input logic [1:0] lane);
    logic [LANES-1:0] be;
    be = '0;
    case (size_e'(size))
      SIZE_BYTE: be = 4'b0001 << lane;
      SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_memory_sized_load_align.sv
// Combinational load formatter: selects the addressed byte/half/word from a
// 32-bit memory word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    result = '0;
    case (size_e'(size))
      SIZE_BYTE: result = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      SIZE_HALF: result = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      SIZE_WORD: result = word;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Word-organised data memory with byte/half/word accesses, registered load
// response and misalignment / out-of-range fault detection.
module data_memory_sized
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       write_data,
  output logic              resp_valid,
  output logic [31:0]       read_data,
  output logic              misaligned,
  output logic              range_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [IDX_W-1:0]          idx;
  logic [1:0]                lane;
  logic                      range_fault;
  logic                      align_fault;
  logic                      accept;
  logic                      do_store;
  logic                      do_load;
  logic [LANES-1:0]          lane_we;
  logic [LANES-1:0][7:0]     store_lanes;
  logic [31:0]               word_rd;
  logic [31:0]               load_value;

  logic [LANES-1:0][7:0] mem [DEPTH_WORDS];

  assign idx         = address[IDX_W+1:2];
  assign lane        = address[1:0];
  assign range_fault = |address[ADDR_W-1:IDX_W+2];

  always_comb begin
    align_fault = 1'b0;
    case (size_e'(req_size))
      SIZE_BYTE: align_fault = 1'b0;
      SIZE_HALF: align_fault = address[0];
      SIZE_WORD: align_fault = |address[1:0];
      default:   align_fault = 1'b1;
    endcase
  end

  // Requests seen during reset are dropped entirely.
  assign accept   = req_valid & ~reset;
  assign do_store = accept &  req_write & ~align_fault & ~range_fault;
  assign do_load  = accept & ~req_write & ~align_fault & ~range_fault;
  assign lane_we  = do_store ? byte_enable(req_size, lane) : '0;

  // Right-aligned store data replicated so each lane sees its own slice.
  always_comb begin
    store_lanes = write_data;
    case (size_e'(req_size))
      SIZE_BYTE: store_lanes = {4{write_data[7:0]}};
      SIZE_HALF: store_lanes = {2{write_data[15:0]}};
      default:   store_lanes = write_data;
    endcase
  end

  // NOTE: the array has no reset; contents survive reset and only lane
  // enables decide what is written.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (lane_we[l]) mem[idx][l] <= store_lanes[l];
    end
  end

  assign word_rd = mem[idx];

  load_align u_load_align (
    .word        (word_rd),
    .lane        (lane),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .result      (load_value)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      read_data  <= '0;
      misaligned <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      resp_valid <= req_valid;
      read_data  <= do_load ? load_value : '0;
      misaligned <= req_valid & align_fault;
      range_err  <= req_valid & range_fault;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: each request pushes its expected
// response, which is compared against the output sampled after the edge.
module tb_data_memory_sized;
  import mem_pkg::*;

  typedef struct packed {
    logic        rv;
    logic [31:0] rd;
    logic        mis;
    logic        rng;
  } resp_t;

  typedef struct {
    resp_t r;
    bit    any_data;
    string name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        misaligned;
  logic        range_err;

  exp_t  exp_q[$];
  resp_t obs_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  localparam resp_t IDLE = '{rv: 1'b0, rd: 32'h0, mis: 1'b0, rng: 1'b0};

  data_memory_sized #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .address      (address),
    .write_data   (write_data),
    .resp_valid   (resp_valid),
    .read_data    (read_data),
    .misaligned   (misaligned),
    .range_err    (range_err)
  );

  always #5 clk = ~clk;

  function automatic resp_t mk(input logic rv, input logic [31:0] rd,
                               input logic mis, input logic rng);
    resp_t r;
    r.rv = rv; r.rd = rd; r.mis = mis; r.rng = rng;
    return r;
  endfunction

  // Drive one cycle of stimulus, queue its expected response, sample after the edge.
  task automatic drive_req(input bit rst, input bit v, input bit w,
                           input logic [1:0] sz, input bit u,
                           input logic [31:0] a, input logic [31:0] wd,
                           input resp_t e, input bit any_data, input string name);
    exp_t x;
    reset = rst; req_valid = v; req_write = w; req_size = sz;
    req_unsigned = u; address = a; write_data = wd;
    x.r = e; x.any_data = any_data; x.name = name;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    obs_q.push_back(mk(resp_valid, read_data, misaligned, range_err));
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    drive_req(1, 0, 0, SIZE_WORD, 0, 32'h0, 32'h0, IDLE, 0, "reset_c1");
    drive_req(1, 0, 0, SIZE_WORD, 0, 32'h0, 32'h0, IDLE, 0, "reset_c2");
    drive_req(0, 0, 0, SIZE_WORD, 0, 32'h0, 32'h0, IDLE, 0, "idle_after_reset");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h0, 32'h0, mk(1, 0, 0, 0), 1, "first_lw_valid");
    drive_req(0, 0, 0, SIZE_WORD, 0, 32'h0, 32'h0, IDLE, 0, "idle_after_lw");
    while (exp_q.size() > 0) begin
      exp_t  e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      tests_run++;
      if (e.any_data ? ({o.rv, o.mis, o.rng} !== {e.r.rv, e.r.mis, e.r.rng}) : (o !== e.r)) begin
        tests_failed++;
        $display("FAIL %s: got rv=%b rd=%h mis=%b rng=%b, want rv=%b rd=%h mis=%b rng=%b",
                 e.name, o.rv, o.rd, o.mis, o.rng, e.r.rv, e.r.rd, e.r.mis, e.r.rng);
      end
    end
  endtask

  task automatic test_back_to_back;
    drive_req(0, 1, 1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, mk(1, 0, 0, 0), 0, "sw_10");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0, mk(1, 32'hDEADBEEF, 0, 0), 0, "lw_10_b2b");
    drive_req(0, 1, 0, SIZE_WORD, 1, 32'h10, 32'h0, mk(1, 32'hDEADBEEF, 0, 0), 0, "lw_10_uns_ignored");
    drive_req(0, 1, 0, SIZE_BYTE, 1, 32'h12, 32'h0, mk(1, 32'h000000AD, 0, 0), 0, "lbu_12");
    drive_req(0, 0, 0, SIZE_WORD, 0, 32'h10, 32'h0, IDLE, 0, "idle_b2b");
    while (exp_q.size() > 0) begin
      exp_t  e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      tests_run++;
      if (o !== e.r) begin
        tests_failed++;
        $display("FAIL %s: got rv=%b rd=%h mis=%b rng=%b, want rv=%b rd=%h mis=%b rng=%b",
                 e.name, o.rv, o.rd, o.mis, o.rng, e.r.rv, e.r.rd, e.r.mis, e.r.rng);
      end
    end
  endtask

  task automatic test_lanes;
    drive_req(0, 1, 1, SIZE_WORD, 0, 32'h20, 32'h00000000, mk(1, 0, 0, 0), 0, "sw_20_zero");
    drive_req(0, 1, 1, SIZE_BYTE, 0, 32'h23, 32'hAAAAAA80, mk(1, 0, 0, 0), 0, "sb_23");
    drive_req(0, 1, 1, SIZE_HALF, 0, 32'h20, 32'h55557FFF, mk(1, 0, 0, 0), 0, "sh_20");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h20, 32'h0, mk(1, 32'h80007FFF, 0, 0), 0, "lw_20");
    drive_req(0, 1, 0, SIZE_BYTE, 0, 32'h23, 32'h0, mk(1, 32'hFFFFFF80, 0, 0), 0, "lb_23");
    drive_req(0, 1, 0, SIZE_BYTE, 1, 32'h23, 32'h0, mk(1, 32'h00000080, 0, 0), 0, "lbu_23");
    drive_req(0, 1, 0, SIZE_HALF, 0, 32'h20, 32'h0, mk(1, 32'h00007FFF, 0, 0), 0, "lh_20");
    drive_req(0, 1, 0, SIZE_HALF, 0, 32'h22, 32'h0, mk(1, 32'hFFFF8000, 0, 0), 0, "lh_22");
    drive_req(0, 1, 0, SIZE_HALF, 1, 32'h22, 32'h0, mk(1, 32'h00008000, 0, 0), 0, "lhu_22");
    drive_req(0, 1, 0, SIZE_BYTE, 0, 32'h21, 32'h0, mk(1, 32'h0000007F, 0, 0), 0, "lb_21");
    drive_req(0, 1, 0, SIZE_BYTE, 0, 32'h22, 32'h0, mk(1, 32'h00000000, 0, 0), 0, "lb_22");
    while (exp_q.size() > 0) begin
      exp_t  e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      tests_run++;
      if (o !== e.r) begin
        tests_failed++;
        $display("FAIL %s: got rv=%b rd=%h mis=%b rng=%b, want rv=%b rd=%h mis=%b rng=%b",
                 e.name, o.rv, o.rd, o.mis, o.rng, e.r.rv, e.r.rd, e.r.mis, e.r.rng);
      end
    end
  endtask

  task automatic test_misaligned;
    drive_req(0, 1, 1, SIZE_WORD, 0, 32'h30, 32'hCAFEF00D, mk(1, 0, 0, 0), 0, "sw_30");
    drive_req(0, 1, 1, SIZE_WORD, 0, 32'h31, 32'h12345678, mk(1, 0, 1, 0), 0, "sw_31_mis");
    drive_req(0, 1, 1, SIZE_HALF, 0, 32'h33, 32'h0000FFFF, mk(1, 0, 1, 0), 0, "sh_33_mis");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h30, 32'h0, mk(1, 32'hCAFEF00D, 0, 0), 0, "lw_30_unchanged");
    drive_req(0, 1, 0, SIZE_HALF, 0, 32'h33, 32'h0, mk(1, 0, 1, 0), 0, "lh_33_mis");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h32, 32'h0, mk(1, 0, 1, 0), 0, "lw_32_mis");
    drive_req(0, 1, 0, SIZE_RSVD, 0, 32'h0, 32'h0, mk(1, 0, 1, 0), 0, "size11_mis");
    drive_req(0, 1, 0, SIZE_HALF, 1, 32'h32, 32'h0, mk(1, 32'h0000CAFE, 0, 0), 0, "lhu_32_ok");
    drive_req(0, 0, 0, SIZE_WORD, 0, 32'h31, 32'h0, IDLE, 0, "idle_mis");
    while (exp_q.size() > 0) begin
      exp_t  e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      tests_run++;
      if (o !== e.r) begin
        tests_failed++;
        $display("FAIL %s: got rv=%b rd=%h mis=%b rng=%b, want rv=%b rd=%h mis=%b rng=%b",
                 e.name, o.rv, o.rd, o.mis, o.rng, e.r.rv, e.r.rd, e.r.mis, e.r.rng);
      end
    end
  endtask

  task automatic test_range;
    drive_req(0, 1, 1, SIZE_WORD, 0, 32'h0, 32'h0BADF00D, mk(1, 0, 0, 0), 0, "sw_0");
    drive_req(0, 1, 1, SIZE_WORD, 0, 32'h3FC, 32'h13579BDF, mk(1, 0, 0, 0), 0, "sw_3fc_last");
    drive_req(0, 1, 1, SIZE_WORD, 0, 32'h400, 32'hFFFFFFFF, mk(1, 0, 0, 1), 0, "sw_400_rng");
    drive_req(0, 1, 1, SIZE_BYTE, 0, 32'h8000_0000, 32'h11, mk(1, 0, 0, 1), 0, "sb_msb_rng");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h0, 32'h0, mk(1, 32'h0BADF00D, 0, 0), 0, "lw_0_unchanged");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h3FC, 32'h0, mk(1, 32'h13579BDF, 0, 0), 0, "lw_3fc");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h400, 32'h0, mk(1, 0, 0, 1), 0, "lw_400_rng");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h401, 32'h0, mk(1, 0, 1, 1), 0, "lw_401_both");
    while (exp_q.size() > 0) begin
      exp_t  e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      tests_run++;
      if (o !== e.r) begin
        tests_failed++;
        $display("FAIL %s: got rv=%b rd=%h mis=%b rng=%b, want rv=%b rd=%h mis=%b rng=%b",
                 e.name, o.rv, o.rd, o.mis, o.rng, e.r.rv, e.r.rd, e.r.mis, e.r.rng);
      end
    end
  endtask

  task automatic test_reset_mid;
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0, mk(1, 32'hDEADBEEF, 0, 0), 0, "lw_10_before_rst");
    drive_req(1, 1, 1, SIZE_WORD, 0, 32'h10, 32'h11111111, IDLE, 0, "rst_drops_resp");
    drive_req(1, 0, 0, SIZE_WORD, 0, 32'h10, 32'h0, IDLE, 0, "rst_hold");
    drive_req(0, 0, 0, SIZE_WORD, 0, 32'h10, 32'h0, IDLE, 0, "idle_after_rst");
    drive_req(0, 1, 0, SIZE_WORD, 0, 32'h10, 32'h0, mk(1, 32'hDEADBEEF, 0, 0), 0, "lw_10_after_rst");
    while (exp_q.size() > 0) begin
      exp_t  e = exp_q.pop_front();
      resp_t o = obs_q.pop_front();
      tests_run++;
      if (o !== e.r) begin
        tests_failed++;
        $display("FAIL %s: got rv=%b rd=%h mis=%b rng=%b, want rv=%b rd=%h mis=%b rng=%b",
                 e.name, o.rv, o.rd, o.mis, o.rng, e.r.rv, e.r.rd, e.r.mis, e.r.rng);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lanes();
    test_misaligned();
    test_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
